// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Program counter and fetch stage sitting in front of the 1024 x 9-bit
// instruction ROM.
//
// The ROM is asynchronous. It takes imem_addr and returns imem_instr in the
// same cycle. On each rising edge the fetch register captures that word and
// holds it for the decoder.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse, (re)starts execution at RESET_PC
//   stall          in   decoder busy, hold PC and fetch register
//   branch_taken   in   redirect request from execute
//   branch_target  in   absolute redirect address
//   imem_addr      out  ROM address (always equal to the PC register)
//   imem_instr     in   ROM data for imem_addr
//   instr_out      out  registered instruction for the decoder
//   instr_pc       out  address instr_out was fetched from
//   instr_valid    out  instr_out is a live instruction
//   done           out  high while halted
//   fetch_count    out  saturating count of loaded instructions
//                       (only present when FETCH_PERF_CNT_EN is defined)
//
// Optional feature macro: FETCH_PERF_CNT_EN
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                   PC_W       = 10,
    parameter int                   INSTR_W    = 9,
    parameter logic [PC_W-1:0]      RESET_PC   = '0,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = '1,
    parameter logic [INSTR_W-1:0]   NOP_INSTR  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_target,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [PC_W-1:0]     instr_pc,
    output logic                instr_valid,
    output logic                done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]         fetch_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      pc_nxt;
    logic [INSTR_W-1:0]   out_nxt;
    logic [PC_W-1:0]      opc_nxt;
    logic                 valid_nxt;
    logic                 done_nxt;

    // The ROM is addressed straight from the PC register. No adder or mux
    // sits on this path, so the ROM gets the whole cycle.
    assign imem_addr = pc;

    // State register and fetch register.
    // Everything returns to its reset value as soon as rst_n falls. Release
    // of rst_n is expected to be synchronised upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr_out   <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_out   <= out_nxt;
            instr_pc    <= opc_nxt;
            instr_valid <= valid_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state and next-datapath logic.
    // Every register holds by default, which also covers a stall.
    // A start pulse is checked before anything else, in any state. It
    // restarts from RESET_PC and drops whatever is in flight.
    // In RUN, a taken branch beats a stall. The fetch already in flight is
    // wrong-path, so it is replaced by a NOP bubble.
    // When the halt word is fetched it is still delivered as a valid
    // instruction. The PC is frozen on it and the unit parks in HALTED.
    // In HALTED the halt word stays valid for as long as the decoder
    // stalls, so the decoder is guaranteed to see it.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        out_nxt   = instr_out;
        opc_nxt   = instr_pc;
        valid_nxt = instr_valid;
        done_nxt  = done;

        if (start) begin
            state_nxt = ST_RUN;
            pc_nxt    = RESET_PC;
            out_nxt   = NOP_INSTR;
            valid_nxt = 1'b0;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_nxt = 1'b0;
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        pc_nxt    = branch_target;
                        out_nxt   = NOP_INSTR;
                        valid_nxt = 1'b0;
                    end else if (!stall) begin
                        out_nxt   = imem_instr;
                        opc_nxt   = pc;
                        valid_nxt = 1'b1;
                        if (imem_instr == HALT_INSTR) begin
                            state_nxt = ST_HALTED;
                            done_nxt  = 1'b1;
                        end else begin
                            pc_nxt = pc + PC_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    if (!stall) begin
                        valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load;

    // A new instruction is loaded only by the plain fetch path in RUN.
    // Restarts, flushes and stalls do not count. The halt word does count.
    assign load = (state == ST_RUN) && !start && !branch_taken && !stall;

    // Performance counter.
    // It saturates instead of wrapping, so a long run never reads back as a
    // small number. Any accepted start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (start) begin
            fetch_count <= '0;
        end else if (load && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Testbench for fetch_unit. It runs directed scenarios and then a
// randomized phase.
//
// A behavioural model tracks what the decoder should see after every clock
// edge. The model steps over the program held in a ROM array, and its
// expected outputs are compared against the DUT at each step.
//
// Compile with +define+FETCH_PERF_CNT_EN to also cover fetch_count.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] NOP  = 9'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  branch_target = '0;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_instr;
    logic [8:0]  instr_out;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif

    logic [8:0]  rom [1024];

    int checks = 0;
    int errors = 0;

    // Model state. mode: 0 = idle, 1 = running, 2 = halted.
    int          m_mode;
    int          m_pc;
    logic [8:0]  m_out;
    int          m_opc;
    logic        m_valid;
    logic        m_done;
    int          m_cnt;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .done          (done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    // Free-running clock with a 10 time-unit period.
    always #5 clk = ~clk;

    // The ROM is combinational, like the real instruction ROM.
    assign imem_instr = rom[imem_addr];

    task automatic modelReset();
        m_mode  = 0;
        m_pc    = 0;
        m_out   = NOP;
        m_opc   = 0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_cnt   = 0;
    endtask

    // Advances the model by one clock edge, using the inputs as they were
    // sampled at that edge.
    task automatic modelStep();
        if (start) begin
            m_mode  = 1;
            m_pc    = 0;
            m_out   = NOP;
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_cnt   = 0;
        end else if (m_mode == 1) begin
            if (branch_taken) begin
                m_pc    = int'(branch_target);
                m_out   = NOP;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_out   = rom[m_pc];
                m_opc   = m_pc;
                m_valid = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (m_out == HALT) begin
                    m_mode = 2;
                    m_done = 1'b1;
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end else if (m_mode == 2) begin
            if (!stall) m_valid = 1'b0;
        end
    endtask

    task automatic checkField(input string tag, input logic [15:0] got,
                              input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".imem_addr"},   16'(imem_addr),   16'(m_pc));
        checkField({tag, ".instr_out"},   16'(instr_out),   16'(m_out));
        checkField({tag, ".instr_pc"},    16'(instr_pc),    16'(m_opc));
        checkField({tag, ".instr_valid"}, 16'(instr_valid), 16'(m_valid));
        checkField({tag, ".done"},        16'(done),        16'(m_done));
`ifdef FETCH_PERF_CNT_EN
        checkField({tag, ".fetch_count"}, fetch_count,      16'(m_cnt));
`endif
    endtask

    // Drives one cycle of inputs, lets one rising edge pass, then compares
    // DUT and model 1 time unit after that edge.
    task automatic applyStimulus(input logic s, input logic st, input logic br,
                                 input logic [9:0] tgt, input string tag);
        start         = s;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    // Directed scenarios followed by a randomized phase.
    initial begin
        logic s, st, br;
        logic [9:0] tgt;

        // ROM contents: random non-halt words, a few scattered halts, and a
        // fixed four-word program at address 0.
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
        for (int i = 0; i < 6; i++) rom[$urandom_range(16'h40, 16'h1F0)] = HALT;
        rom[0] = 9'h011;
        rom[1] = 9'h022;
        rom[2] = 9'h033;
        rom[3] = HALT;

        // Reset state, before any clock edge.
        modelReset();
        #3;
        checkOutput("reset");
        checkField("reset.instr_out_nop", 16'(instr_out), 16'(NOP));
        @(negedge clk);
        rst_n = 1'b1;

        // In IDLE, stall and branch_taken have no effect.
        applyStimulus(0, 1, 1, 10'h155, "idle_ignore");
        applyStimulus(0, 0, 1, 10'h0AA, "idle_ignore2");

        // Straight-line program from address 0 up to the halt word.
        applyStimulus(1, 0, 0, 10'h000, "sl_start");
        applyStimulus(0, 0, 0, 10'h000, "sl_f0");
        checkField("sl_f0.const_out", 16'(instr_out), 16'h011);
        applyStimulus(0, 0, 0, 10'h000, "sl_f1");
        checkField("sl_f1.const_out", 16'(instr_out), 16'h022);
        applyStimulus(0, 0, 0, 10'h000, "sl_f2");
        checkField("sl_f2.const_pc", 16'(instr_pc), 16'h002);
        applyStimulus(0, 0, 0, 10'h000, "sl_halt");
        checkField("sl_halt.const_done", 16'(done), 16'h1);
        checkField("sl_halt.const_addr", 16'(imem_addr), 16'h003);
        applyStimulus(0, 0, 0, 10'h000, "sl_halted");
        checkField("sl_halted.const_valid", 16'(instr_valid), 16'h0);
        applyStimulus(0, 0, 1, 10'h100, "halted_branch_ignored");

        // Restart from HALTED, then stall for three cycles while 022 is
        // sitting in the fetch register.
        applyStimulus(1, 0, 0, 10'h000, "restart_halted");
        checkField("restart_halted.const_done", 16'(done), 16'h0);
        applyStimulus(0, 0, 0, 10'h000, "st_f0");
        applyStimulus(0, 0, 0, 10'h000, "st_f1");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 10'h000, "st_hold");
            checkField("st_hold.const_out", 16'(instr_out), 16'h022);
            checkField("st_hold.const_addr", 16'(imem_addr), 16'h002);
        end
        applyStimulus(0, 0, 0, 10'h000, "st_resume");
        checkField("st_resume.const_out", 16'(instr_out), 16'h033);

        // Branch to 5, then a second branch from PC 5 to 0x200.
        applyStimulus(1, 0, 0, 10'h000, "br_start");
        applyStimulus(0, 0, 1, 10'h005, "br_to5");
        applyStimulus(0, 0, 1, 10'h200, "br_to200");
        checkField("br_to200.const_addr", 16'(imem_addr), 16'h200);
        applyStimulus(0, 0, 0, 10'h000, "br_f200");
        checkField("br_f200.const_pc", 16'(instr_pc), 16'h200);

        // A branch and a stall in the same cycle: the branch wins. The branch
        // lands on 0x3FF, so the next fetch address wraps to 0.
        applyStimulus(0, 1, 1, 10'h3FF, "br_stall");
        checkField("br_stall.const_addr", 16'(imem_addr), 16'h3FF);
        applyStimulus(0, 0, 0, 10'h000, "wrap");
        checkField("wrap.const_addr", 16'(imem_addr), 16'h000);

        // A start in RUN beats a simultaneous branch and stall.
        applyStimulus(1, 1, 1, 10'h123, "restart_run");
        applyStimulus(0, 0, 0, 10'h000, "restart_run_f0");

        // Perf scenario: four loads, two stall cycles and one flush.
        applyStimulus(1, 0, 0, 10'h000, "pc_start");
        applyStimulus(0, 0, 0, 10'h000, "pc_l0");
        applyStimulus(0, 0, 0, 10'h000, "pc_l1");
        applyStimulus(0, 1, 0, 10'h000, "pc_s0");
        applyStimulus(0, 1, 0, 10'h000, "pc_s1");
        applyStimulus(0, 0, 1, 10'h002, "pc_flush");
        applyStimulus(0, 0, 0, 10'h000, "pc_l2");
        applyStimulus(0, 0, 0, 10'h000, "pc_l3");
`ifdef FETCH_PERF_CNT_EN
        checkField("pc_done.const_count", fetch_count, 16'd4);
`endif
        applyStimulus(1, 0, 0, 10'h000, "pc_restart");
`ifdef FETCH_PERF_CNT_EN
        checkField("pc_restart.const_count", fetch_count, 16'd0);
`endif

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(0, 29) == 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 5) == 0);
            tgt = 10'($urandom_range(0, 1023));
            applyStimulus(s, st, br, tgt, "rand");
        end

        // Asynchronous reset in the middle of a run. The outputs must reach
        // their reset values with no clock edge in between.
        applyStimulus(1, 0, 0, 10'h000, "ar_start");
        applyStimulus(0, 0, 0, 10'h000, "ar_f0");
        applyStimulus(0, 0, 0, 10'h000, "ar_f1");
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        checkField("async_reset.const_valid", 16'(instr_valid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 10'h000, "post_reset_idle");

        $display("[TB] run complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
